// File: rtl/adder_share_ctrl.sv
// Two-requester front end for one external 4-bit adder slice.
// Each granted WIDTH-bit add runs nibble-serially, LSB first, with the carry kept in a register.
module adder_share_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_req0_valid,
   output logic             o_req0_ready,
   input  logic [WIDTH-1:0] i_req0_a,
   input  logic [WIDTH-1:0] i_req0_b,
   input  logic             i_req0_cin,
   input  logic             i_req1_valid,
   output logic             o_req1_ready,
   input  logic [WIDTH-1:0] i_req1_a,
   input  logic [WIDTH-1:0] i_req1_b,
   input  logic             i_req1_cin,
   output logic             o_rsp_valid,
   input  logic             i_rsp_ready,
   output logic             o_rsp_id,
   output logic [WIDTH-1:0] o_rsp_sum,
   output logic             o_rsp_cout,
   output logic [3:0]       o_add_a,
   output logic [3:0]       o_add_b,
   output logic             o_add_cin,
   input  logic [3:0]       i_add_sum,
   input  logic             i_add_cout
);

   localparam int N  = WIDTH / 4;
   localparam int KW = (N > 1) ? $clog2(N) : 1;

   generate
      if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_bad_width
         $error("adder_share_ctrl: WIDTH must be a multiple of 4 and at least 4");
      end
   endgenerate

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic                r_ptr;
   logic                r_id;
   logic                r_carry;
   logic [KW-1:0]       r_k;
   logic [N-1:0][3:0]   r_a;
   logic [N-1:0][3:0]   r_b;
   logic [N-1:0][3:0]   r_sum;

   logic                w_any;
   logic                w_gnt_id;
   logic                w_accept;
   logic                w_last;

   // Readies are gated by rst_n so nothing is granted while reset is held.
   assign w_any    = rst_n & (i_req0_valid | i_req1_valid);
   assign w_gnt_id = (i_req0_valid & i_req1_valid) ? r_ptr : i_req1_valid;
   assign w_accept = (r_state == S_IDLE) & w_any;
   assign w_last   = (r_k == KW'(N - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      o_req0_ready = 1'b0;
      o_req1_ready = 1'b0;
      o_add_a      = 4'h0;
      o_add_b      = 4'h0;
      o_add_cin    = 1'b0;
      case (r_state)
         S_IDLE: begin
            o_req0_ready = w_accept & ~w_gnt_id;
            o_req1_ready = w_accept &  w_gnt_id;
            if (w_accept) begin
               w_state_next = S_RUN;
            end
         end
         S_RUN: begin
            o_add_a   = r_a[r_k];
            o_add_b   = r_b[r_k];
            o_add_cin = r_carry;
            if (w_last) begin
               w_state_next = S_DONE;
            end
         end
         S_DONE: begin
            if (i_rsp_ready) begin
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr   <= 1'b0;
         r_id    <= 1'b0;
         r_carry <= 1'b0;
         r_k     <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_a     <= w_gnt_id ? i_req1_a   : i_req0_a;
                  r_b     <= w_gnt_id ? i_req1_b   : i_req0_b;
                  r_carry <= w_gnt_id ? i_req1_cin : i_req0_cin;
                  r_id    <= w_gnt_id;
                  r_ptr   <= ~w_gnt_id;
                  r_k     <= '0;
               end
            end
            S_RUN: begin
               r_sum[r_k] <= i_add_sum;
               r_carry    <= i_add_cout;
               if (!w_last) begin
                  r_k <= r_k + KW'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign o_rsp_valid = (r_state == S_DONE);
   assign o_rsp_id    = r_id;
   assign o_rsp_sum   = r_sum;
   assign o_rsp_cout  = r_carry;

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Bench for adder_share_ctrl: arithmetic reference model checked every cycle plus directed literal cases.
module tb_adder_share_ctrl;
   localparam int W = 16;
   localparam int N = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req0_valid, req0_ready, req0_cin;
   logic          req1_valid, req1_ready, req1_cin;
   logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
   logic          rsp_valid, rsp_ready, rsp_id, rsp_cout;
   logic [W-1:0]  rsp_sum;
   logic [3:0]    add_a, add_b, add_sum;
   logic          add_cin, add_cout;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   // External adder slice
   assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

   adder_share_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req0_valid(req0_valid), .o_req0_ready(req0_ready), .i_req0_a(req0_a),
      .i_req0_b(req0_b), .i_req0_cin(req0_cin),
      .i_req1_valid(req1_valid), .o_req1_ready(req1_ready), .i_req1_a(req1_a),
      .i_req1_b(req1_b), .i_req1_cin(req1_cin),
      .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_id(rsp_id),
      .o_rsp_sum(rsp_sum), .o_rsp_cout(rsp_cout),
      .o_add_a(add_a), .o_add_b(add_b), .o_add_cin(add_cin),
      .i_add_sum(add_sum), .i_add_cout(add_cout)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: tracks one operation as "busy for N slice cycles, then result pending".
   bit           m_busy = 1'b0;
   int           m_cnt  = 0;
   bit           m_ptr  = 1'b0;
   bit           m_id   = 1'b0;
   bit           m_cin  = 1'b0;
   int unsigned  m_a    = 0;
   int unsigned  m_b    = 0;

   always @(negedge clk) begin
      int unsigned mask, carry_in, total;
      logic e0, e1;
      bit gid;
      if (!rst_n) begin
         chk("rst_outputs", 32'({rsp_valid, rsp_id, rsp_cout, rsp_sum, req0_ready, req1_ready}), 32'd0);
         chk("rst_adder", 32'({add_a, add_b, add_cin}), 32'd0);
         m_busy = 1'b0;
         m_ptr  = 1'b0;
      end else if (!m_busy) begin
         e0 = 1'b0;
         e1 = 1'b0;
         if (req0_valid && req1_valid) begin
            e0 = ~m_ptr;
            e1 = m_ptr;
         end else begin
            e0 = req0_valid;
            e1 = req1_valid;
         end
         chk("idle_ready", 32'({req0_ready, req1_ready}), 32'({e0, e1}));
         chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
         chk("idle_adder", 32'({add_a, add_b, add_cin}), 32'd0);
         if (req0_valid || req1_valid) begin
            gid    = (req0_valid && req1_valid) ? m_ptr : req1_valid;
            m_a    = gid ? 32'(req1_a) : 32'(req0_a);
            m_b    = gid ? 32'(req1_b) : 32'(req0_b);
            m_cin  = gid ? req1_cin : req0_cin;
            m_id   = gid;
            m_ptr  = ~gid;
            m_busy = 1'b1;
            m_cnt  = 0;
         end
      end else if (m_cnt < N) begin
         mask     = (32'd1 << (4 * m_cnt)) - 32'd1;
         carry_in = ((m_a & mask) + (m_b & mask) + 32'(m_cin)) >> (4 * m_cnt);
         chk("run_add_a", 32'(add_a), (m_a >> (4 * m_cnt)) & 32'hF);
         chk("run_add_b", 32'(add_b), (m_b >> (4 * m_cnt)) & 32'hF);
         chk("run_add_cin", 32'(add_cin), carry_in);
         chk("run_ready", 32'({req0_ready, req1_ready, rsp_valid}), 32'd0);
         m_cnt++;
      end else begin
         total = m_a + m_b + 32'(m_cin);
         chk("done_valid", 32'(rsp_valid), 32'd1);
         chk("done_result", 32'({rsp_cout, rsp_sum}), total & 32'h1FFFF);
         chk("done_id", 32'(rsp_id), 32'(m_id));
         chk("done_ready", 32'({req0_ready, req1_ready}), 32'd0);
         chk("done_adder", 32'({add_a, add_b, add_cin}), 32'd0);
         if (rsp_ready) m_busy = 1'b0;
      end
   end

   // Directed request with hand-computed result, per-slice carry chain and response hold.
   task automatic do_req(input bit id, input logic [15:0] a, input logic [15:0] b, input bit cin,
                         input logic [15:0] es, input bit ec, input logic [3:0] ecin, input int hold);
      bit got;
      logic [3:0] cv;
      @(posedge clk); #1;
      if (id) begin req1_valid = 1; req1_a = a; req1_b = b; req1_cin = cin; end
      else    begin req0_valid = 1; req0_a = a; req0_b = b; req0_cin = cin; end
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk);
         got = id ? req1_ready : req0_ready;
      end
      chk("accept", 32'(got), 32'd1);
      @(posedge clk); #1;
      req0_valid = 0; req1_valid = 0;
      req0_a = 16'(a ^ 16'h5A5A); req1_a = 16'(b ^ 16'hA5A5);
      req0_b = 16'hDEAD; req1_b = 16'hBEEF;
      if (!got) return;
      cv = 4'h0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         cv[k] = add_cin;
      end
      chk("cin_chain", 32'(cv), 32'(ecin));
      @(negedge clk);
      chk("latency_valid", 32'(rsp_valid), 32'd1);
      chk("lit_sum", 32'(rsp_sum), 32'(es));
      chk("lit_cout", 32'(rsp_cout), 32'(ec));
      chk("lit_id", 32'(rsp_id), 32'(id));
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("hold_stable", 32'({rsp_valid, rsp_id, rsp_cout, rsp_sum}), 32'({1'b1, id, ec, es}));
         chk("hold_quiet", 32'({req0_ready, req1_ready, add_a, add_b, add_cin}), 32'd0);
      end
      if (hold > 0) begin
         @(posedge clk); #1;
         rsp_ready = 1;
      end
      @(posedge clk); #1;
   endtask

   initial begin
      int ids[$];
      bit got;
      req0_valid = 0; req1_valid = 0; req0_cin = 0; req1_cin = 0;
      req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
      rsp_ready = 1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1;

      // 1: reset asserted mid-operation
      @(posedge clk); #1;
      req0_valid = 1; req0_a = 16'h1234; req0_b = 16'h1111;
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk);
         got = req0_ready;
      end
      chk("t1_accept", 32'(got), 32'd1);
      @(posedge clk); #1 req0_valid = 0;
      @(posedge clk); #1 rst_n = 0;
      #1;
      chk("t1_rst_adder", 32'({add_a, add_b, add_cin}), 32'd0);
      chk("t1_rst_rsp", 32'({rsp_valid, rsp_sum, rsp_cout, rsp_id}), 32'd0);
      @(posedge clk); #1 rst_n = 1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("t1_no_rsp", 32'(rsp_valid), 32'd0);
      end

      // 2..4 and 6
      do_req(1'b0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 4'b0110, 0);
      do_req(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 4'b1111, 0);
      do_req(1'b0, 16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 4'b1110, 0);
      rsp_ready = 0;
      do_req(1'b1, 16'hA5A5, 16'h5A5A, 1'b1, 16'h0000, 1'b1, 4'b1111, 5);

      // 5: both requesters valid continuously from reset
      @(posedge clk); #1 rst_n = 0;
      req0_valid = 1; req0_a = 16'h1111; req0_b = 16'h2222; req0_cin = 0;
      req1_valid = 1; req1_a = 16'h8000; req1_b = 16'h8000; req1_cin = 1;
      @(posedge clk); #1 rst_n = 1;
      for (int c = 0; c < 4 * (N + 2) + 10; c++) begin
         @(negedge clk);
         if (rsp_valid && rsp_ready) begin
            ids.push_back(int'(rsp_id));
            if (ids.size() == 1) chk("t5_sum0", 32'({rsp_cout, rsp_sum}), 32'h03333);
            if (ids.size() == 2) chk("t5_sum1", 32'({rsp_cout, rsp_sum}), 32'h10001);
         end
      end
      chk("t5_count_ge4", 32'(ids.size() >= 4), 32'd1);
      for (int i = 0; i < 4 && i < ids.size(); i++) begin
         chk("t5_rr_id", 32'(ids[i]), 32'(i % 2));
      end
      req0_valid = 0; req1_valid = 0;
      repeat (10) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
